fifo_tx: RTL and testbench
==========================

FIFO_TX -- requirements
Module: fifo_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the data word width in bits.
REQ-002 The block SHALL have parameter DIV, default 4, giving the clock cycles per serial bit; legal range is 1 to 256.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port rdata, input, WIDTH bits: FIFO read data, first-word fall-through, valid whenever empty=0.
REQ-006 The block SHALL have port empty, input, 1 bit: FIFO empty flag.
REQ-007 The block SHALL have port ren, output, 1 bit: FIFO pop strobe, combinational.
REQ-008 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have port frames, output, 8 bits: count of completed frames, wrapping 255->0.

Function
REQ-011 The state machine SHALL have the states IDLE, START, DATA, [PARITY], STOP.
REQ-012 Each non-IDLE state SHALL last DIV cycles, timed by a bit counter of width max(1,clog2(DIV)) that counts 0..DIV-1.
REQ-013 The block SHALL drive ren = ~empty & (IDLE | (STOP & cnt==DIV-1)), and SHALL never assert ren while RESET=1 or in any other state.
REQ-014 In the cycle ren=1, rdata SHALL be captured into the shift register, with the state going to START and cnt to 0 on the next edge.
REQ-015 In IDLE with empty=1, the block SHALL stay in IDLE with tx=1.
REQ-016 In START, tx SHALL be 0.
REQ-017 In DATA, tx SHALL be the shift register LSB, and the register SHALL shift right once per bit, for WIDTH bits, LSB first.
REQ-018 A bit index SHALL count 0..WIDTH-1, and DATA SHALL exit after index WIDTH-1 at cnt==DIV-1.
REQ-019 In STOP, tx SHALL be 1.
REQ-020 At the end of STOP (cnt==DIV-1), frames SHALL increment.
REQ-021 At the end of STOP with empty=0, the block SHALL pop and go directly to START, leaving no idle gap between frames.
REQ-022 At the end of STOP with empty=1, the block SHALL go to IDLE.
REQ-023 Frame length SHALL be (2+WIDTH)*DIV cycles, or (3+WIDTH)*DIV cycles with parity.
REQ-024 First-frame latency SHALL be 1 cycle: a pop in cycle N gives the start bit on tx from cycle N+1.
REQ-025 tx SHALL be a registered output, glitch-free.
REQ-026 A change of empty mid-frame SHALL be ignored; it is sampled only at the ren points.
REQ-027 With DIV=1, every state SHALL last exactly one cycle.

Reset
REQ-028 While RESET=1, the block SHALL hold state=IDLE, cnt=0, bit index=0, shift register=0, tx=1, busy=0, frames=0 and ren=0, taking effect immediately and independent of CLK.
REQ-029 A reset asserted mid-frame SHALL abort the frame with no pop and no frames increment, and tx SHALL return high asynchronously.
REQ-030 On the first edge after RESET falls with empty=0, the block SHALL pop the head word.

Configuration
REQ-031 The block SHALL provide the macro FIFO_TX_PARITY_EN.
REQ-032 With FIFO_TX_PARITY_EN defined, a PARITY state of DIV cycles SHALL be inserted between DATA and STOP, driving tx = XOR of the WIDTH data bits (even parity) computed at capture.
REQ-033 Without FIFO_TX_PARITY_EN, there SHALL be no PARITY state, no parity logic, and DATA SHALL go directly to STOP.

Verification
REQ-034 Reset then idle: RESET pulse, empty=1 for 50 cycles -> tx=1, ren=0, busy=0, frames=0 throughout.
REQ-035 Single word: WIDTH=5, DIV=4, no parity, rdata=5'b10110, empty 1->0 at cycle 10 -> ren=1 in cycle 10 only; tx over 28 cycles from cycle 11 is 0,0,1,1,0,1,1 (4 cycles each); frames=1; back to IDLE.
REQ-036 Back-to-back: three words 5'h01, 5'h1F, 5'h0A queued, DIV=4 -> three ren pulses spaced 28 cycles apart; no tx-high gap beyond the stop bits; frames=3 after 84 cycles.
REQ-037 Parity build: FIFO_TX_PARITY_EN, rdata=5'b10110 -> parity bit 1; rdata=5'b10010 -> parity bit 0; frame length 32 cycles at DIV=4.
REQ-038 Reset mid-frame: RESET asserted during DATA bit 2 -> tx=1 in the same cycle, busy=0, frames unchanged, no pop; after release with empty=0, the next word is popped on the first edge.
REQ-039 Wrap and DIV=1: 256 frames at DIV=1, WIDTH=5 -> each frame 7 cycles; frames wraps to 0 at frame 256.

Source files
------------

// File: rtl/fifo_tx.sv
// fifo_tx: drains a first-word-fall-through FIFO onto a serial line.
// Frame on tx: start bit (0), WIDTH data bits LSB first, optional even parity bit,
// stop bit (1). Every symbol lasts DIV clocks; back-to-back words leave no idle gap.
// Build option: define FIFO_TX_PARITY_EN to insert the even-parity bit before STOP.
module fifo_tx #(
    parameter int WIDTH = 5,
    parameter int DIV   = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] rdata,
    input  logic             empty,
    output logic             ren,
    output logic             tx,
    output logic             busy,
    output logic [7:0]       frames
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef FIFO_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [IW-1:0]    idx, idx_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic             tx_nx;
    logic             frame_done;
    logic             cnt_last;
`ifdef FIFO_TX_PARITY_EN
    logic             par_q;
`endif

    assign cnt_last = (cnt == CNT_LAST);
    assign busy     = (state != IDLE);

    // Next-state, bit timing, shift-register and pop-strobe decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nx   = state;
        cnt_nx     = cnt;
        idx_nx     = idx;
        shreg_nx   = shreg;
        frame_done = 1'b0;
        // The pop is gated by RESET so the FIFO is never drained while the block is held.
        ren = ~RESET & ~empty & ((state == IDLE) | ((state == STOP) & cnt_last));

        if (state != IDLE) begin
            cnt_nx = cnt_last ? '0 : cnt + CW'(1);
        end

        case (state)
            IDLE: begin
                state_nx = IDLE;
            end
            START: begin
                if (cnt_last) begin
                    state_nx = DATA;
                    idx_nx   = '0;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    shreg_nx = shreg >> 1;
                    if (idx == IDX_LAST) begin
`ifdef FIFO_TX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end else begin
                        idx_nx = idx + IW'(1);
                    end
                end
            end
`ifdef FIFO_TX_PARITY_EN
            PARITY: begin
                if (cnt_last) state_nx = STOP;
            end
`endif
            STOP: begin
                if (cnt_last) begin
                    frame_done = 1'b1;
                    state_nx   = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // A pop always starts a fresh frame, whether from IDLE or straight out of STOP.
        if (ren) begin
            state_nx = START;
            cnt_nx   = '0;
            idx_nx   = '0;
            shreg_nx = rdata;
        end
    end

    // Line level for the coming cycle, registered below so tx never glitches.
    always_comb begin
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shreg_nx[0];
`ifdef FIFO_TX_PARITY_EN
            PARITY:  tx_nx = par_q;
`endif
            default: tx_nx = 1'b1;
        endcase
    end

    // State, datapath and frame counter registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            // NOTE: the shift register is reset too, so a released block never replays stale data.
            shreg  <= '0;
            tx     <= 1'b1;
            frames <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state  <= state_nx;
            cnt    <= cnt_nx;
            idx    <= idx_nx;
            shreg  <= shreg_nx;
            tx     <= tx_nx;
            if (frame_done) frames <= frames + 8'd1;
        end
    end

`ifdef FIFO_TX_PARITY_EN
    // Even parity of the whole word, taken once at capture.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            par_q <= 1'b0;
        end else if (ren) begin
            par_q <= ^rdata;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_tx.sv
// tb_fifo_tx: scoreboard bench for fifo_tx. Words pushed into a behavioural FIFO are
// also queued as expected frames; a line monitor decodes tx and compares each frame.
// A second instance at DIV=1 streams 256 frames to exercise the counter wrap.
module tb_fifo_tx;

    localparam int WIDTH = 5;
    localparam int DIV   = 4;
`ifdef FIFO_TX_PARITY_EN
    localparam int NBITS = WIDTH + 3;
`else
    localparam int NBITS = WIDTH + 2;
`endif
    localparam int LEN  = NBITS * DIV;
    localparam int LEN1 = NBITS;

    logic             CLK    = 1'b0;
    logic             RESET  = 1'b1;
    logic [WIDTH-1:0] rdata  = '0;
    logic             empty  = 1'b1;
    logic             ren, tx, busy;
    logic [7:0]       frames;

    logic [WIDTH-1:0] rdata1 = '0;
    logic             empty1 = 1'b1;
    logic             ren1, tx1, busy1;
    logic [7:0]       frames1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int               pop_cyc[$];
    int               pop_count  = 0;
    int               frames_exp = 0;

    logic             d1_bits[$];
    int               d1_pops = 0;
    int               d1_last = 0;

    fifo_tx #(.WIDTH(WIDTH), .DIV(DIV)) u_dut (
        .CLK(CLK), .RESET(RESET), .rdata(rdata), .empty(empty),
        .ren(ren), .tx(tx), .busy(busy), .frames(frames)
    );

    fifo_tx #(.WIDTH(WIDTH), .DIV(1)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .rdata(rdata1), .empty(empty1),
        .ren(ren1), .tx(tx1), .busy(busy1), .frames(frames1)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line image of one frame; element 0 goes out first.
    function automatic logic [NBITS-1:0] frame_bits(input logic [WIDTH-1:0] w);
`ifdef FIFO_TX_PARITY_EN
        return {1'b1, ^w, w, 1'b0};
`else
        return {1'b1, w, 1'b0};
`endif
    endfunction

    task automatic tick();
        @(negedge CLK);
        #2;
    endtask

    task automatic drive_fifo();
        empty = (fifo_q.size() == 0);
        rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        frames_exp++;
        drive_fifo();
    endtask

    task automatic wait_idle(input int budget, output int busy_cycles);
        bit done;
        done = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < budget; i++) begin
            if (fifo_q.size() == 0 && busy === 1'b0) begin
                done = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
            tick();
        end
        check("idle_reached", done, 1);
    endtask

    // Behavioural FIFO for the DIV=4 instance: pops on the edge where ren was high.
    initial begin : fifo_model
        logic p;
        forever begin
            @(posedge CLK);
            p = ren;
            #1;
            if (p === 1'b1 && fifo_q.size() > 0) begin
                void'(fifo_q.pop_front());
                pop_count++;
                pop_cyc.push_back(cyc);
                drive_fifo();
            end
        end
    end

    // Line monitor: a falling tx starts a frame, which is compared to the next queued word.
    initial begin : line_monitor
        logic [WIDTH-1:0] word, rx;
        logic [NBITS-1:0] bits;
        int bad, sym;
        bit aborted;
        forever begin
            @(negedge CLK);
            if (RESET === 1'b0 && tx === 1'b0) begin
                check("sb_word_expected", exp_q.size() > 0, 1);
                word = '0;
                if (exp_q.size() > 0) word = exp_q.pop_front();
                bits    = frame_bits(word);
                bad     = 0;
                aborted = 1'b0;
                rx      = '0;
                for (int s = 0; s < LEN; s++) begin
                    if (s > 0) @(negedge CLK);
                    if (RESET === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    sym = s / DIV;
                    if (tx !== bits[sym]) bad++;
                    if ((s % DIV) == DIV / 2 && sym >= 1 && sym <= WIDTH) rx[sym-1] = tx;
                end
                if (!aborted) begin
                    check("frame_wave", bad, 0);
                    check("frame_word", rx, word);
                end
            end
        end
    end

    // Feed and timing checks for the DIV=1 instance.
    initial begin : fifo1_model
        logic p;
        logic [NBITS-1:0] b;
        forever begin
            @(posedge CLK);
            p = ren1;
            #1;
            if (p === 1'b1) begin
                if (d1_pops > 0) check("d1_spacing", cyc - d1_last, LEN1);
                check("d1_frames_at_pop", frames1, d1_pops % 256);
                b = frame_bits(rdata1);
                for (int k = 0; k < NBITS; k++) d1_bits.push_back(b[k]);
                d1_last = cyc;
                d1_pops++;
                rdata1 = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
                if (d1_pops == 256) empty1 = 1'b1;
            end
        end
    end

    initial begin : line1_monitor
        logic e;
        forever begin
            @(negedge CLK);
            if (d1_bits.size() > 0) begin
                e = d1_bits.pop_front();
                check("d1_tx", tx1, e);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int viol, bc, base, pc;

        // Reset, then a long idle stretch with the FIFO empty.
        repeat (3) tick();
        #1;
        check("rst_tx", tx, 1);
        check("rst_ren", ren, 0);
        check("rst_busy", busy, 0);
        check("rst_frames", frames, 0);
        RESET = 1'b0;
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx !== 1'b1 || ren !== 1'b0 || busy !== 1'b0 || frames !== 8'd0) viol++;
        end
        check("idle50_viol", viol, 0);

        // Single word: one pop, start bit on the very next cycle, exact frame length.
        repeat (10) tick();
        pc = pop_count;
        push(5'b10110);
        #1;
        check("single_ren", ren, 1);
        check("single_tx_before", tx, 1);
        tick();
        #1;
        check("single_ren_once", ren, 0);
        check("single_first_bit", tx, 0);
        check("single_pop", pop_count - pc, 1);
        wait_idle(200, bc);
        check("single_len", bc, LEN);
        check("single_frames", frames, 8'(frames_exp));
        check("single_tx_idle", tx, 1);
        check("single_one_pop", pop_count - pc, 1);

        // Back-to-back: three queued words go out without any gap.
        base = pop_cyc.size();
        push(5'h01);
        push(5'h1F);
        push(5'h0A);
        tick();
        wait_idle(400, bc);
        check("b2b_pops", pop_cyc.size() - base, 3);
        if (pop_cyc.size() - base >= 3) begin
            check("b2b_gap1", pop_cyc[base+1] - pop_cyc[base], LEN);
            check("b2b_gap2", pop_cyc[base+2] - pop_cyc[base+1], LEN);
        end
        check("b2b_busy", bc, 3 * LEN);
        check("b2b_frames", frames, 8'(frames_exp));

        // Reset during DATA bit 2: abort, no pop, then pop on the first edge after release.
        repeat (5) tick();
        pc = pop_count;
        push(5'b11011);
        #1;
        check("rmid_ren", ren, 1);
        repeat (14) tick();
        #1;
        check("rmid_bit2", tx, 0);
        RESET = 1'b1;
        frames_exp = 0;
        #1;
        check("rmid_tx_async", tx, 1);
        check("rmid_busy", busy, 0);
        check("rmid_frames", frames, 0);
        push(5'b01001);
        #1;
        check("rmid_ren_in_reset", ren, 0);
        repeat (2) tick();
        check("rmid_no_pop", pop_count - pc, 1);
        RESET = 1'b0;
        #1;
        check("rel_ren", ren, 1);
        tick();
        #1;
        check("rel_pop", pop_count - pc, 2);
        check("rel_start", tx, 0);
        wait_idle(200, bc);
        check("rel_frames", frames, 8'(frames_exp));

        // Random traffic: bursts and gaps, pushes land at arbitrary points in a frame.
        for (int i = 0; i < 40; i++) begin
            int burst;
            burst = $urandom_range(1, 3);
            for (int b = 0; b < burst; b++) push(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)));
            repeat ($urandom_range(0, 70)) tick();
        end
        wait_idle(6000, bc);
        check("rand_frames", frames, 8'(frames_exp % 256));
        check("rand_sb_drained", exp_q.size(), 0);

        // DIV=1 stream of 256 frames: 7-cycle frames and the 255->0 wrap.
        tick();
        rdata1 = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        empty1 = 1'b0;
        begin
            bit done;
            done = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                tick();
                if (d1_pops == 256 && busy1 === 1'b0) begin
                    done = 1'b1;
                    break;
                end
            end
            check("d1_done", done, 1);
        end
        check("d1_pops", d1_pops, 256);
        check("d1_wrap", frames1, 0);
        check("d1_tx_idle", tx1, 1);
        check("d1_bits_drained", d1_bits.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
